// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes and oversample ratio.
// Intended for both the receiver and the transmitter on the same link.
package uart_pkg;

  localparam int OVS = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Resets to 1 so a line that is idle never looks like a falling edge.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_logic.sv
// 16x oversampled UART receiver: start-glitch rejection, mid-cell sampling,
// optional parity, per-frame done strobe with framing/parity flags.
module uart_rx_logic
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [3:0] S_MID   = 4'(OVS / 2 - 1);
  localparam logic [3:0] S_LAST  = 4'(OVS - 1);
  localparam logic [3:0] SB_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);
  localparam logic       ODD     = (PARITY == PAR_ODD);

  logic rx_sync, rx_prev_q, start_det;

  state_e            state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [2:0]        n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic              perr_q, perr_d;
  logic [7:0]        dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              perrf_q, perrf_d;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_sync)
  );

  // Edge detect, not level: a held-low break cannot retrigger a frame.
  assign start_det = rx_prev_q & ~rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      perr_q    <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perrf_q   <= 1'b0;
    end else begin
      rx_prev_q <= rx_sync;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      perr_q    <= perr_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      perrf_q   <= perrf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    perr_d  = perr_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    perrf_d = perrf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            // Line back high at mid start bit means it was a glitch.
            if (!rx_sync) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            b_d = {rx_sync, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            else               n_d = n_q + 3'd1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_PAR: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            perr_d  = (^b_q) ^ rx_sync ^ ODD;
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == SB_LAST) begin
            dout_d  = 8'(b_q);
            ferr_d  = ~rx_sync;
            perrf_d = perr_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perrf_q;

endmodule

// File: tb/tb_uart_rx_logic.sv
// Directed bench: four receivers (8N1, 8E1, 8O1, 7N1) on separate lines
// sharing clock, reset and a s_tick strobe every 4 clk (64 clk per bit).
module tb_uart_rx_logic;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic [3:0] rx_l = 4'hF;
  logic [7:0] dout_w [4];
  logic [3:0] done_w, ferr_w, perr_w;

  int cnt [4];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_logic #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_n8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_l[0]), .dout(dout_w[0]),
    .rx_done_tick(done_w[0]), .frame_err(ferr_w[0]), .parity_err(perr_w[0]));
  uart_rx_logic #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_e8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_l[1]), .dout(dout_w[1]),
    .rx_done_tick(done_w[1]), .frame_err(ferr_w[1]), .parity_err(perr_w[1]));
  uart_rx_logic #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_o8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_l[2]), .dout(dout_w[2]),
    .rx_done_tick(done_w[2]), .frame_err(ferr_w[2]), .parity_err(perr_w[2]));
  uart_rx_logic #(.DBIT(7), .SB_TICK(16), .PARITY(0)) u_n7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_l[3]), .dout(dout_w[3]),
    .rx_done_tick(done_w[3]), .frame_err(ferr_w[3]), .parity_err(perr_w[3]));

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Counts high cycles of each done strobe, so a wide pulse shows up as extra frames.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (done_w[i] === 1'b1) cnt[i]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input int idx, input logic v);
    rx_l[idx] = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] data, input int nb,
                            input int pbit, input logic stopb);
    drive_bit(idx, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(idx, data[i]);
    if (pbit >= 0) drive_bit(idx, pbit[0]);
    drive_bit(idx, stopb);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({dout_w[i], done_w[i], ferr_w[i], perr_w[i]} !== 11'h0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got dout=%h done=%b ferr=%b perr=%b, want all 0",
                 i, dout_w[i], done_w[i], ferr_w[i], perr_w[i]);
      end
    end
    reset = 1'b0;
    repeat (64) @(negedge clk);
  endtask

  task automatic test_basic;
    int c0 = cnt[0];
    send_frame(0, 8'hA5, 8, -1, 1'b1);
    n_cmp++;
    if (cnt[0] !== c0 + 1) begin n_err++; $display("FAIL a5_count: got %0d want %0d", cnt[0], c0 + 1); end
    n_cmp++;
    if (dout_w[0] !== 8'hA5) begin n_err++; $display("FAIL a5_dout: got %h want a5", dout_w[0]); end
    n_cmp++;
    if ({ferr_w[0], perr_w[0]} !== 2'b00) begin
      n_err++; $display("FAIL a5_flags: got ferr=%b perr=%b want 0 0", ferr_w[0], perr_w[0]);
    end
    repeat (64) @(negedge clk);
  endtask

  task automatic test_glitch;
    int c0 = cnt[0];
    rx_l[0] = 1'b0;
    repeat (12) @(negedge clk);
    rx_l[0] = 1'b1;
    repeat (128) @(negedge clk);
    n_cmp++;
    if (cnt[0] !== c0) begin n_err++; $display("FAIL glitch_no_done: got %0d want %0d", cnt[0], c0); end
    send_frame(0, 8'h3C, 8, -1, 1'b1);
    n_cmp++;
    if (cnt[0] !== c0 + 1) begin n_err++; $display("FAIL glitch_3c_count: got %0d want %0d", cnt[0], c0 + 1); end
    n_cmp++;
    if (dout_w[0] !== 8'h3C) begin n_err++; $display("FAIL glitch_3c_dout: got %h want 3c", dout_w[0]); end
    repeat (64) @(negedge clk);
  endtask

  task automatic test_break;
    int c0 = cnt[0];
    send_frame(0, 8'h55, 8, -1, 1'b0);
    n_cmp++;
    if (cnt[0] !== c0 + 1) begin n_err++; $display("FAIL ferr_count: got %0d want %0d", cnt[0], c0 + 1); end
    n_cmp++;
    if (dout_w[0] !== 8'h55) begin n_err++; $display("FAIL ferr_dout: got %h want 55", dout_w[0]); end
    n_cmp++;
    if (ferr_w[0] !== 1'b1) begin n_err++; $display("FAIL ferr_flag: got %b want 1", ferr_w[0]); end
    repeat (40 * 64) @(negedge clk);
    n_cmp++;
    if (cnt[0] !== c0 + 1) begin n_err++; $display("FAIL break_spurious: got %0d want %0d", cnt[0], c0 + 1); end
    n_cmp++;
    if (ferr_w[0] !== 1'b1) begin n_err++; $display("FAIL ferr_held: got %b want 1", ferr_w[0]); end
    rx_l[0] = 1'b1;
    repeat (128) @(negedge clk);
    send_frame(0, 8'h81, 8, -1, 1'b1);
    n_cmp++;
    if (cnt[0] !== c0 + 2) begin n_err++; $display("FAIL post_break_count: got %0d want %0d", cnt[0], c0 + 2); end
    n_cmp++;
    if ({dout_w[0], ferr_w[0]} !== {8'h81, 1'b0}) begin
      n_err++; $display("FAIL post_break_81: got dout=%h ferr=%b want 81 0", dout_w[0], ferr_w[0]);
    end
    repeat (64) @(negedge clk);
  endtask

  task automatic test_parity;
    int c1 = cnt[1];
    int c2 = cnt[2];
    send_frame(1, 8'h07, 8, 1, 1'b1);
    n_cmp++;
    if ({cnt[1], dout_w[1], ferr_w[1], perr_w[1]} !== {c1 + 1, 8'h07, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL even_ok: got cnt=%0d dout=%h ferr=%b perr=%b want %0d 07 0 0",
                        cnt[1], dout_w[1], ferr_w[1], perr_w[1], c1 + 1);
    end
    repeat (64) @(negedge clk);
    send_frame(1, 8'h07, 8, 0, 1'b1);
    n_cmp++;
    if ({cnt[1], dout_w[1], perr_w[1]} !== {c1 + 2, 8'h07, 1'b1}) begin
      n_err++; $display("FAIL even_bad: got cnt=%0d dout=%h perr=%b want %0d 07 1",
                        cnt[1], dout_w[1], perr_w[1], c1 + 2);
    end
    send_frame(2, 8'h07, 8, 0, 1'b1);
    n_cmp++;
    if ({cnt[2], dout_w[2], ferr_w[2], perr_w[2]} !== {c2 + 1, 8'h07, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL odd_ok: got cnt=%0d dout=%h ferr=%b perr=%b want %0d 07 0 0",
                        cnt[2], dout_w[2], ferr_w[2], perr_w[2], c2 + 1);
    end
    repeat (64) @(negedge clk);
    send_frame(2, 8'h07, 8, 1, 1'b1);
    n_cmp++;
    if (perr_w[2] !== 1'b1) begin n_err++; $display("FAIL odd_bad: got perr=%b want 1", perr_w[2]); end
    repeat (64) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int c3 = cnt[3];
    send_frame(3, 8'h7F, 7, -1, 1'b1);
    n_cmp++;
    if ({cnt[3], dout_w[3]} !== {c3 + 1, 8'h7F}) begin
      n_err++; $display("FAIL d7_7f: got cnt=%0d dout=%h want %0d 7f", cnt[3], dout_w[3], c3 + 1);
    end
    send_frame(3, 8'h00, 7, -1, 1'b1);
    n_cmp++;
    if ({cnt[3], dout_w[3], ferr_w[3]} !== {c3 + 2, 8'h00, 1'b0}) begin
      n_err++; $display("FAIL d7_00: got cnt=%0d dout=%h ferr=%b want %0d 00 0",
                        cnt[3], dout_w[3], ferr_w[3], c3 + 2);
    end
    repeat (64) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    int c0 = cnt[0];
    logic [7:0] d = 8'hF5;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    rx_l[0] = d[4];
    repeat (32) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dout_w[0], done_w[0], ferr_w[0], perr_w[0]} !== 11'h0) begin
      n_err++; $display("FAIL midframe_reset: got dout=%h done=%b ferr=%b perr=%b want all 0",
                        dout_w[0], done_w[0], ferr_w[0], perr_w[0]);
    end
    n_cmp++;
    if (dout_w[1] !== 8'h00) begin n_err++; $display("FAIL midframe_reset_e8: got dout=%h want 00", dout_w[1]); end
    reset = 1'b0;
    repeat (31) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(0, d[i]);
    drive_bit(0, 1'b1);
    repeat (128) @(negedge clk);
    n_cmp++;
    if (cnt[0] !== c0) begin n_err++; $display("FAIL partial_no_done: got %0d want %0d", cnt[0], c0); end
    send_frame(0, 8'hC3, 8, -1, 1'b1);
    n_cmp++;
    if ({cnt[0], dout_w[0], ferr_w[0]} !== {c0 + 1, 8'hC3, 1'b0}) begin
      n_err++; $display("FAIL after_reset_c3: got cnt=%0d dout=%h ferr=%b want %0d c3 0",
                        cnt[0], dout_w[0], ferr_w[0], c0 + 1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_break;
    test_parity;
    test_back_to_back;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
